// File: rtl/spi_master_pkg.sv
// spi_pkg: shared SPI mode/state encodings and CPOL/CPHA bit positions.
// Imported by spi_master; no optional features live here.
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GUARD = 3'd4
    } spi_state_e;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: local start/ready/done handshake plus the four SPI pins.
// master modport is the controller view, slave modport the user/peer view.
interface spi_master_if #(
    parameter int DATA_W = 8
);

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        mode;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              m_SCK;
    logic              m_MOSI;
    logic              m_MISO;
    logic              m_SS;

    modport master (
        input  start, tx_data, mode, m_MISO,
        output ready, busy, done, rx_data,
        output m_SCK, m_MOSI, m_SS
    );

    modport slave (
        output start, tx_data, mode, m_MISO,
        input  ready, busy, done, rx_data,
        input  m_SCK, m_MOSI, m_SS
    );

endinterface

// File: rtl/spi_master_clk_gen.sv
// spi_clk_gen: SCK half-period down-counter, ticks every CLK_DIV cycles.
// Held at its reload value whenever run is low.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // count down while running, reload at terminal count or when stopped
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_cnt <= RELOAD;
        end else if (r_cnt == '0) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = run && (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// spi_master: single-word SPI master, all four modes, LSB first by default.
// Define SPI_MASTER_MSB_FIRST_EN to shift MSB first instead.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);

    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    spi_state_e        r_state;
    spi_state_e        w_next;
    spi_mode_e         r_mode;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_rx;
    logic [EW-1:0]     r_edge;
    logic              r_sck;
    logic              r_mosi;
    logic              r_ss;
    logic              r_done;

    logic              w_tick;
    logic              w_run;
    logic              w_last;
    logic              w_sample;
    logic              w_ready;
    logic              w_busy;
    logic [EW-1:0]     w_edge_nx;
    logic [DATA_W-1:0] w_shifted;
    logic              w_first;
    logic              w_next_bit;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .tick (w_tick)
    );

    assign w_run     = (r_state != IDLE);
    assign w_edge_nx = r_edge + 1'b1;
    assign w_last    = (w_edge_nx == LAST_EDGE);
    // odd edges are leading; CPHA flips which edge samples
    assign w_sample  = w_edge_nx[0] ^ r_mode[CPHA_BIT];

`ifdef SPI_MASTER_MSB_FIRST_EN
    assign w_shifted  = {r_shreg[DATA_W-2:0], bus.m_MISO};
    assign w_first    = bus.tx_data[DATA_W-1];
    assign w_next_bit = r_shreg[DATA_W-1];
`else
    assign w_shifted  = {bus.m_MISO, r_shreg[DATA_W-1:1]};
    assign w_first    = bus.tx_data[0];
    assign w_next_bit = r_shreg[0];
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state: every phase after IDLE advances on a half-period tick
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next = SETUP;
            SETUP:   if (w_tick) w_next = SHIFT;
            SHIFT:   if (w_tick && w_last) w_next = HOLD;
            HOLD:    if (w_tick) w_next = GUARD;
            GUARD:   if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // handshake status decoded from state
    always_comb begin
        w_ready = (r_state == IDLE);
        w_busy  = (r_state == SETUP) || (r_state == SHIFT) ||
                  (r_state == HOLD);
    end

    // datapath: capture, SCK toggling, shift/drive, result and SS
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_ss    <= 1'b1;
            r_done  <= 1'b0;
            r_rx    <= '0;
            r_mode  <= SPI_MODE0;
            r_shreg <= '0;
            r_edge  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_sck <= bus.mode[CPOL_BIT];
                    if (bus.start) begin
                        r_shreg <= bus.tx_data;
                        r_mode  <= spi_mode_e'(bus.mode);
                        r_mosi  <= w_first;
                        r_ss    <= 1'b0;
                        r_edge  <= '0;
                    end
                end
                SETUP, SHIFT: begin
                    if (w_tick) begin
                        r_sck  <= ~r_sck;
                        r_edge <= w_edge_nx;
                        if (w_sample) begin
                            r_shreg <= w_shifted;
                        end else begin
                            r_mosi <= w_next_bit;
                        end
                    end
                end
                HOLD: begin
                    r_sck <= r_mode[CPOL_BIT];
                    if (w_tick) begin
                        r_ss   <= 1'b1;
                        r_done <= 1'b1;
                        r_rx   <= r_shreg;
                    end
                end
                default: begin
                    r_sck <= r_mode[CPOL_BIT];
                end
            endcase
        end
    end

    assign bus.ready   = w_ready;
    assign bus.busy    = w_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx;
    assign bus.m_SCK   = r_sck;
    assign bus.m_MOSI  = r_mosi;
    assign bus.m_SS    = r_ss;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master at CLK_DIV=4 and CLK_DIV=1.
// Expected values follow SPI_MASTER_MSB_FIRST_EN when it is defined.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    spi_master_if #(.DATA_W(8)) b0 ();
    spi_master_if #(.DATA_W(8)) b1 ();

    spi_master #(.DATA_W(8), .CLK_DIV(4)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    spi_master #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    always #5 clk = ~clk;

    // slave model: LSB first, mode 0, preloaded with slv_data
    logic       use_slv  = 1'b0;
    logic [7:0] slv_data = 8'h00;
    logic [7:0] s_rx     = 8'h00;
    logic [2:0] s_idx    = 3'd0;

    always @(posedge b0.m_SCK) begin
        if (!b0.m_SS) s_rx <= {b0.m_MOSI, s_rx[7:1]};
    end

    always @(negedge b0.m_SCK or posedge b0.m_SS) begin
        if (b0.m_SS) s_idx <= 3'd0;
        else         s_idx <= s_idx + 3'd1;
    end

    assign b0.m_MISO = use_slv ? slv_data[s_idx] : b0.m_MOSI;
    assign b1.m_MISO = b1.m_MOSI;

    // activity counters for dut0: SS-low cycles, SCK edges, sample edges
    int   ss_low0 = 0;
    int   edges0  = 0;
    int   samp0   = 0;
    int   viol0   = 0;
    logic sck_q0  = 1'b0;
    logic mosi_q0 = 1'b0;

    always @(negedge clk) begin
        if (!b0.m_SS) ss_low0++;
        if (!b0.m_SS && b0.m_SCK !== sck_q0) begin
            edges0++;
            if ((b0.m_SCK != b0.mode[1]) ^ b0.mode[0]) begin
                samp0++;
                if (b0.m_MOSI !== mosi_q0) viol0++;
            end
        end
        sck_q0  = b0.m_SCK;
        mosi_q0 = b0.m_MOSI;
    end

    // activity counters for dut1
    int   ss_low1 = 0;
    int   edges1  = 0;
    logic sck_q1  = 1'b0;

    always @(negedge clk) begin
        if (!b1.m_SS) ss_low1++;
        if (!b1.m_SS && b1.m_SCK !== sck_q1) edges1++;
        sck_q1 = b1.m_SCK;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer0(input logic [1:0] m, input logic [7:0] d,
                         output logic [7:0] rx, output int k);
        int w;
        @(negedge clk);
        b0.mode    = m;
        b0.tx_data = d;
        b0.start   = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        k = 1;
        while (b0.done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("x0_done_seen", b0.done, 1);
        rx = b0.rx_data;
        w = 0;
        while (b0.ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("x0_ready_back", b0.ready, 1);
    endtask

    task automatic xfer1(input logic [7:0] d, output logic [7:0] rx,
                         output int k, output logic first);
        int w;
        @(negedge clk);
        b1.mode    = 2'd0;
        b1.tx_data = d;
        b1.start   = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        first = b1.m_MOSI;
        k = 1;
        while (b1.done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("x1_done_seen", b1.done, 1);
        rx = b1.rx_data;
        w = 0;
        while (b1.ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("x1_ready_back", b1.ready, 1);
    endtask

    initial begin
        logic [7:0] rx;
        logic [1:0] m;
        logic       first;
        int         k;
        int         a_ss, a_ed, a_sp, a_vi;
        int         run, nf, nd, gmin, cy, ne;
        logic       pss, prev;
        logic [7:0] exp_m, exp_s;

        b0.start = 1'b0; b0.tx_data = 8'h00; b0.mode = 2'd0;
        b1.start = 1'b0; b1.tx_data = 8'h00; b1.mode = 2'd0;

        // reset values
        @(negedge clk);
        chk("rst_ss",    b0.m_SS,    1);
        chk("rst_sck",   b0.m_SCK,   0);
        chk("rst_mosi",  b0.m_MOSI,  0);
        chk("rst_busy",  b0.busy,    0);
        chk("rst_done",  b0.done,    0);
        chk("rst_ready", b0.ready,   1);
        chk("rst_rx",    b0.rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // mode 0 loopback, 3C: timing and edge counts
        a_ss = ss_low0; a_ed = edges0; a_sp = samp0; a_vi = viol0;
        xfer0(2'd0, 8'h3C, rx, k);
        chk("m0_rx",        rx,             8'h3C);
        chk("m0_done_lat",  k,              69);
        chk("m0_ss_low",    ss_low0 - a_ss, 68);
        chk("m0_edges",     edges0 - a_ed,  16);
        chk("m0_samp_edges", samp0 - a_sp,  8);
        chk("m0_samp_viol", viol0 - a_vi,   0);
        chk("m0_sck_idle",  b0.m_SCK,       0);

        // modes 1..3 loopback, A5
        for (int i = 1; i < 4; i++) begin
            m = 2'(i);
            @(negedge clk);
            b0.mode = m;
            repeat (2) @(negedge clk);
            chk("mx_sck_idle_pre", b0.m_SCK, {31'd0, m[1]});
            a_ed = edges0; a_sp = samp0; a_vi = viol0;
            xfer0(m, 8'hA5, rx, k);
            chk("mx_rx",         rx,            8'hA5);
            chk("mx_edges",      edges0 - a_ed, 16);
            chk("mx_samp_edges", samp0 - a_sp,  8);
            chk("mx_samp_viol",  viol0 - a_vi,  0);
            chk("mx_sck_idle",   b0.m_SCK,      {31'd0, m[1]});
        end

        // against the slave model preloaded with AA
        @(negedge clk);
        b0.mode  = 2'd0;
        slv_data = 8'hAA;
        use_slv  = 1'b1;
        repeat (2) @(negedge clk);
        xfer0(2'd0, 8'h0F, rx, k);
`ifdef SPI_MASTER_MSB_FIRST_EN
        exp_m = 8'h55;
        exp_s = 8'hF0;
`else
        exp_m = 8'hAA;
        exp_s = 8'h0F;
`endif
        chk("slv_master_rx", rx,   exp_m);
        chk("slv_slave_rx",  s_rx, exp_s);
        use_slv = 1'b0;

        // start held high: exactly three transfers
        @(negedge clk);
        b0.tx_data = 8'h5A;
        b0.start   = 1'b1;
        run = 0; nf = 0; nd = 0; gmin = 1000; cy = 0; pss = 1'b1;
        while (cy < 600) begin
            @(negedge clk);
            cy++;
            if (b0.done) nd++;
            if (b0.m_SS) begin
                run++;
            end else if (pss) begin
                nf++;
                if (nf > 1 && run < gmin) gmin = run;
                run = 0;
            end
            pss = b0.m_SS;
            if (nf == 3) b0.start = 1'b0;
            if (nf == 3 && b0.ready) break;
        end
        b0.start = 1'b0;
        chk("hold_xfers",  nf,         3);
        chk("hold_dones",  nd,         3);
        chk("hold_gap_ok", gmin >= 4,  1);
        chk("hold_rx",     b0.rx_data, 8'h5A);

        // reset at SCK edge 7
        @(negedge clk);
        b0.mode    = 2'd0;
        b0.tx_data = 8'h3C;
        b0.start   = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        prev = b0.m_SCK;
        ne = 0; cy = 0;
        while (ne < 7 && cy < 200) begin
            @(negedge clk);
            cy++;
            if (b0.m_SCK !== prev) ne++;
            prev = b0.m_SCK;
        end
        chk("rst7_edge_seen", ne, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst7_ss",    b0.m_SS,    1);
        chk("rst7_sck",   b0.m_SCK,   0);
        chk("rst7_busy",  b0.busy,    0);
        chk("rst7_ready", b0.ready,   1);
        chk("rst7_rx",    b0.rx_data, 0);
        nd = 0;
        repeat (100) begin
            @(negedge clk);
            if (b0.done) nd++;
        end
        chk("rst7_no_done", nd, 0);
        xfer0(2'd0, 8'h81, rx, k);
        chk("rst7_next_rx", rx, 8'h81);

        // CLK_DIV=1: SCK = clk/2
        a_ss = ss_low1; a_ed = edges1;
        xfer1(8'hFF, rx, k, first);
        chk("d1_rx",       rx,             8'hFF);
        chk("d1_done_lat", k,              18);
        chk("d1_ss_low",   ss_low1 - a_ss, 17);
        chk("d1_edges",    edges1 - a_ed,  16);

        // first bit order for 80
        xfer1(8'h80, rx, k, first);
`ifdef SPI_MASTER_MSB_FIRST_EN
        chk("d1_first_bit", first, 1);
`else
        chk("d1_first_bit", first, 0);
`endif
        chk("d1_rx80", rx, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
